// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: AXI-lite read/write bundle shared by the IFU, LSU and SRAM ports of the arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin IFU/LSU read arbiter onto one SRAM slave; LSU writes pass straight through.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  sram_arbiter_if.slave  i_ifu,
  sram_arbiter_if.slave  i_lsu,
  sram_arbiter_if.master o_sram
);
  typedef enum logic [2:0] {IDLE, IFU_ADDR, IFU_DATA, LSU_ADDR, LSU_DATA} state_t;
  state_t r_state, w_next;
  logic   r_last_grant;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == IFU_ADDR) r_last_grant <= 1'b0;
      else if (w_next == LSU_ADDR) r_last_grant <= 1'b1;
    end
  end
  // A tie goes to whichever master was not granted last.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (i_lsu.arvalid && (!i_ifu.arvalid || !r_last_grant)) ? LSU_ADDR :
                         i_ifu.arvalid ? IFU_ADDR : IDLE;
      IFU_ADDR: w_next = (i_ifu.arvalid && o_sram.arready) ? IFU_DATA : IFU_ADDR;
      IFU_DATA: w_next = (o_sram.rvalid && i_ifu.rready) ? IDLE : IFU_DATA;
      LSU_ADDR: w_next = (i_lsu.arvalid && o_sram.arready) ? LSU_DATA : LSU_ADDR;
      LSU_DATA: w_next = (o_sram.rvalid && i_lsu.rready) ? IDLE : LSU_DATA;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    o_sram.araddr  = {ADDR_W{1'b0}};
    o_sram.arvalid = 1'b0;
    o_sram.rready  = 1'b0;
    i_ifu.arready  = 1'b0;
    i_ifu.rvalid   = 1'b0;
    i_ifu.rdata    = {DATA_W{1'b0}};
    i_ifu.rresp    = 2'b00;
    i_lsu.arready  = 1'b0;
    i_lsu.rvalid   = 1'b0;
    i_lsu.rdata    = {DATA_W{1'b0}};
    i_lsu.rresp    = 2'b00;
    case (r_state)
      IFU_ADDR: begin
        o_sram.araddr  = i_ifu.araddr;
        o_sram.arvalid = i_ifu.arvalid;
        i_ifu.arready  = o_sram.arready;
      end
      IFU_DATA: begin
        o_sram.rready = i_ifu.rready;
        i_ifu.rvalid  = o_sram.rvalid;
        i_ifu.rdata   = o_sram.rdata;
        i_ifu.rresp   = o_sram.rresp;
      end
      LSU_ADDR: begin
        o_sram.araddr  = i_lsu.araddr;
        o_sram.arvalid = i_lsu.arvalid;
        i_lsu.arready  = o_sram.arready;
      end
      LSU_DATA: begin
        o_sram.rready = i_lsu.rready;
        i_lsu.rvalid  = o_sram.rvalid;
        i_lsu.rdata   = o_sram.rdata;
        i_lsu.rresp   = o_sram.rresp;
      end
      default: ;
    endcase
  end
  assign o_sram.awaddr  = i_lsu.awaddr;
  assign o_sram.awvalid = i_lsu.awvalid;
  assign i_lsu.awready  = o_sram.awready;
  assign o_sram.wdata   = i_lsu.wdata;
  assign o_sram.wstrb   = i_lsu.wstrb;
  assign o_sram.wvalid  = i_lsu.wvalid;
  assign i_lsu.wready   = o_sram.wready;
  assign i_lsu.bresp    = o_sram.bresp;
  assign i_lsu.bvalid   = o_sram.bvalid;
  assign o_sram.bready  = i_lsu.bready;
  // The IFU is read-only, so its write channels are held idle.
  assign i_ifu.awready  = 1'b0;
  assign i_ifu.wready   = 1'b0;
  assign i_ifu.bresp    = 2'b00;
  assign i_ifu.bvalid   = 1'b0;
endmodule
